// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: bus defaults, owner state
// encoding and port indices used by the priority pointer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin conflict resolution).
package dmem_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 1024;

  // Ownership of the memory port; OWN_x means x holds a lock.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  // Priority pointer values: the port that wins the next conflict.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory arbiter; pure combinational.
// Latency: 0 cycles. Backpressure: a losing requester simply sees pick = 0.
// Ports: a_req/b_req requests, owner (owner_e encoding), ptr (conflict
// winner when nobody owns the port), a_pick/b_pick one-hot-or-zero grants.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  logic [1:0] owner,
  input  logic       ptr,
  output logic       a_pick,
  output logic       b_pick
);

  always_comb begin
    a_pick = 1'b0;
    b_pick = 1'b0;
    case (owner)
      NONE: begin
        if (a_req && b_req) begin
          if (ptr == PORT_A) a_pick = 1'b1;
          else               b_pick = 1'b1;
        end else begin
          a_pick = a_req;
          b_pick = b_req;
        end
      end
      // A locked owner is the only eligible port; a locked owner that is not
      // requesting leaves the memory idle rather than lending it out.
      OWN_A:   a_pick = a_req;
      OWN_B:   b_pick = b_req;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory, with lock for RMW.
// Latency: grant combinational in cycle t, response (rvalid/rdata/err) at t+1.
// Backpressure: req/gnt handshake; a loser holds req stable until granted.
// Ports: clk, rst_n (async active-low); per port x in {a,b}: x_req, x_we,
// x_lock, x_addr, x_wdata in; x_gnt, x_rvalid, x_rdata, x_err out.
// Memory side: mem_address, mem_write, mem_read, mem_write_data out;
// mem_read_data in (combinational read).
// Build option: define DMEM_ARB_RR_EN for round-robin conflicts, otherwise
// A has fixed priority over B.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [DATA_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [DATA_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [DATA_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  owner_e owner_q, owner_d;
  logic   ptr;
  logic   a_pick, b_pick;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer moves only on accepted transfers so a waiting loser keeps its turn.
  always_comb begin
    ptr_d = ptr_q;
    if (a_gnt)      ptr_d = PORT_B;
    else if (b_gnt) ptr_d = PORT_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PORT_A;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = PORT_A;
`endif

  dmem_arb_pick u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
    .owner  (owner_q),
    .ptr    (ptr),
    .a_pick (a_pick),
    .b_pick (b_pick)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign a_gnt = a_pick & rst_n;
  assign b_gnt = b_pick & rst_n;

  logic              gnt_any;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  assign gnt_any   = a_gnt | b_gnt;
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;
  // Extra top bit keeps the compare correct even if MEM_DEPTH == 2**DATA_W.
  assign sel_in_range = ({1'b0, sel_addr} < (DATA_W + 1)'(MEM_DEPTH));

  // Out-of-range transfers are granted but never reach the memory.
  assign mem_address    = gnt_any ? sel_addr : '0;
  assign mem_write_data = gnt_any ? sel_wdata : '0;
  assign mem_write      = gnt_any & sel_in_range & sel_we;
  assign mem_read       = gnt_any & sel_in_range & ~sel_we;

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      NONE: begin
        if (a_gnt && a_lock)      owner_d = OWN_A;
        else if (b_gnt && b_lock) owner_d = OWN_B;
      end
      OWN_A: if (!a_lock && (a_gnt || !a_req)) owner_d = NONE;
      OWN_B: if (!b_lock && (b_gnt || !b_req)) owner_d = NONE;
      default: owner_d = NONE;
    endcase
  end

  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  // Reads capture memory data; writes keep the previous rdata; an
  // out-of-range access returns zero data with err set.
  always_comb begin
    a_rvalid_d = a_gnt;
    b_rvalid_d = b_gnt;
    a_err_d    = a_gnt & ~sel_in_range;
    b_err_d    = b_gnt & ~sel_in_range;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_gnt) begin
      if (!sel_in_range) a_rdata_d = '0;
      else if (!sel_we)  a_rdata_d = mem_read_data;
    end
    if (b_gnt) begin
      if (!sel_in_range) b_rdata_d = '0;
      else if (!sel_we)  b_rdata_d = mem_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= NONE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
// Latency: n/a. Backpressure: n/a.
// Memory preload: mem[i] = 0x100 + 0x11*i.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[9:0]];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] data);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = data;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] data);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = data;
  endtask

  logic exp_a;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'h11 * i;
    drv_a(1'b1, 1'b1, 1'b0, 32'd5, 32'h1234);
    drv_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    // Reset state, with A requesting to show nothing leaks through.
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_a_err", a_err, 0);
    tick(); tick();
    drv_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();

    // A write addr 5, then A read addr 5.
    drv_a(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    #1;
    check("wr_a_gnt", a_gnt, 1);
    check("wr_mem_write", mem_write, 1);
    check("wr_mem_read", mem_read, 0);
    check("wr_mem_addr", mem_address, 5);
    tick();
    check("wr_a_rvalid", a_rvalid, 1);
    check("wr_a_rdata_hold", a_rdata, 0);
    drv_a(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    #1;
    check("rd_a_gnt", a_gnt, 1);
    check("rd_mem_read", mem_read, 1);
    tick();
    check("rd_a_rvalid", a_rvalid, 1);
    check("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    check("rd_a_err", a_err, 0);
    drv_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("idle_mem_addr", mem_address, 0);
    check("idle_mem_read", mem_read, 0);
    tick();
    check("idle_a_rvalid", a_rvalid, 0);

    // Lock: B reads 10 with lock, holds with req low, then writes and releases.
    drv_b(1'b1, 1'b0, 1'b1, 32'd10, 32'd0);
    #1;
    check("lk_b_gnt0", b_gnt, 1);
    tick();
    check("lk_b_rvalid", b_rvalid, 1);
    check("lk_b_rdata", b_rdata, 32'h1AA);
    drv_a(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    drv_b(1'b0, 1'b0, 1'b1, 32'd10, 32'd0);
    #1;
    check("lk_hold_a_gnt", a_gnt, 0);
    check("lk_hold_b_gnt", b_gnt, 0);
    tick();
    drv_b(1'b1, 1'b1, 1'b0, 32'd10, 32'h55);
    #1;
    check("lk_wr_a_gnt", a_gnt, 0);
    check("lk_wr_b_gnt", b_gnt, 1);
    tick();
    check("lk_wr_b_rvalid", b_rvalid, 1);
    drv_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("lk_rel_a_gnt", a_gnt, 1);
    tick();
    check("lk_rel_a_rdata", a_rdata, 32'h133);
    check("lk_rel_b_rvalid", b_rvalid, 0);

    // Out of range write, then readback of addr 0.
    drv_a(1'b1, 1'b1, 1'b0, 32'd1024, 32'h1);
    #1;
    check("oor_a_gnt", a_gnt, 1);
    check("oor_mem_write", mem_write, 0);
    check("oor_mem_read", mem_read, 0);
    tick();
    check("oor_a_rvalid", a_rvalid, 1);
    check("oor_a_err", a_err, 1);
    check("oor_a_rdata", a_rdata, 0);
    drv_a(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("oor_rb_rdata", a_rdata, 32'h100);
    check("oor_rb_err", a_err, 0);

    // Back-to-back reads of addr 0..3.
    for (int i = 0; i < 4; i++) begin
      drv_a(1'b1, 1'b0, 1'b0, i, 32'd0);
      #1;
      check("b2b_a_gnt", a_gnt, 1);
      tick();
      check("b2b_a_rvalid", a_rvalid, 1);
      check("b2b_a_rdata", a_rdata, 32'h100 + 32'h11 * i);
    end
    drv_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Single B read (also hands the round-robin turn back to A).
    drv_b(1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
    tick();
    check("b_rd_rdata", b_rdata, 32'h55);

    // Conflict for three cycles: A,A,A fixed; A,B,A round-robin.
    drv_a(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    drv_b(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_RR_EN
      exp_a = (k != 1);
`else
      exp_a = 1'b1;
`endif
      #1;
      check("cf_a_gnt", a_gnt, exp_a);
      check("cf_b_gnt", b_gnt, !exp_a);
      tick();
      check("cf_a_rvalid", a_rvalid, exp_a);
      check("cf_b_rvalid", b_rvalid, !exp_a);
    end
    check("cf_a_rdata", a_rdata, 32'h111);
    drv_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset the cycle after a locked A read is accepted.
    drv_a(1'b1, 1'b0, 1'b1, 32'd2, 32'd0);
    #1;
    check("mr_a_gnt", a_gnt, 1);
    tick();
    check("mr_a_rvalid_pre", a_rvalid, 1);
    rst_n = 1'b0;
    drv_a(1'b0, 1'b0, 1'b1, 32'd2, 32'd0);
    #1;
    check("mr_a_rvalid", a_rvalid, 0);
    check("mr_a_rdata", a_rdata, 0);
    tick();
    rst_n = 1'b1;
    drv_b(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    #1;
    check("mr_b_gnt", b_gnt, 1);
    tick();
    check("mr_b_rvalid", b_rvalid, 1);
    check("mr_b_rdata", b_rdata, 32'h133);
    drv_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
